// File: rtl/exec_cond_eval_pkg.sv
// Shared widths, flag bit positions and condition-code encodings for the
// exec-stage flag consumers (branch evaluation, conditional move).
package exec_cond_eval_pkg;

   localparam int W_FLAGS = 4;
   localparam int W_COND  = 4;
   localparam int W_PEND  = 3;

   localparam int F_C = 0;
   localparam int F_Z = 1;
   localparam int F_S = 2;
   localparam int F_V = 3;

   localparam logic [W_PEND-1:0] PEND_MAX = '1;

   localparam logic [W_COND-1:0] COND_EQ = 4'h0;
   localparam logic [W_COND-1:0] COND_NE = 4'h1;
   localparam logic [W_COND-1:0] COND_CS = 4'h2;
   localparam logic [W_COND-1:0] COND_CC = 4'h3;
   localparam logic [W_COND-1:0] COND_MI = 4'h4;
   localparam logic [W_COND-1:0] COND_PL = 4'h5;
   localparam logic [W_COND-1:0] COND_VS = 4'h6;
   localparam logic [W_COND-1:0] COND_VC = 4'h7;
   localparam logic [W_COND-1:0] COND_HI = 4'h8;
   localparam logic [W_COND-1:0] COND_LS = 4'h9;
   localparam logic [W_COND-1:0] COND_GE = 4'hA;
   localparam logic [W_COND-1:0] COND_LT = 4'hB;
   localparam logic [W_COND-1:0] COND_GT = 4'hC;
   localparam logic [W_COND-1:0] COND_LE = 4'hD;
   localparam logic [W_COND-1:0] COND_AL = 4'hE;
   localparam logic [W_COND-1:0] COND_NV = 4'hF;

endpackage

// File: rtl/exec_cond_eval_cond_decode.sv
// Purely combinational condition-code evaluator: cond + {V,S,Z,C} -> taken.
// No state and no handshake; shared by branch resolution and conditional move.
module cond_decode
   import exec_cond_eval_pkg::*;
(
   input  logic [W_COND-1:0]  cond_i,
   input  logic [W_FLAGS-1:0] flags_i,
   output logic               taken_o
);

   logic v, s, z, c;

   assign v = flags_i[F_V];
   assign s = flags_i[F_S];
   assign z = flags_i[F_Z];
   assign c = flags_i[F_C];

   always_comb begin
      taken_o = 1'b0;
      case (cond_i)
         COND_EQ: taken_o = z;
         COND_NE: taken_o = ~z;
         COND_CS: taken_o = c;
         COND_CC: taken_o = ~c;
         COND_MI: taken_o = s;
         COND_PL: taken_o = ~s;
         COND_VS: taken_o = v;
         COND_VC: taken_o = ~v;
         COND_HI: taken_o = c & ~z;
         COND_LS: taken_o = ~c | z;
         COND_GE: taken_o = (s == v);
         COND_LT: taken_o = (s != v);
         COND_GT: taken_o = ~z & (s == v);
         COND_LE: taken_o = z | (s != v);
         COND_AL: taken_o = 1'b1;
         COND_NV: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/exec_cond_eval.sv
// Architectural flags register plus condition evaluation; response 1 cycle after accept.
// Requests stall (req_ready_o=0) while flag writes are in flight, except for the final write, which is bypassed.
module exec_cond_eval
   import exec_cond_eval_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush_i,
   input  logic               fissue_i,
   input  logic               fwe_i,
   input  logic [W_FLAGS-1:0] flags_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [W_COND-1:0]  req_cond_i,
   output logic               resp_valid_o,
   output logic               resp_taken_o,
   output logic [W_FLAGS-1:0] flags_o,
   output logic [W_PEND-1:0]  pend_o
);

   logic [W_FLAGS-1:0] flags_q, flags_d;
   logic [W_PEND-1:0]  pend_q, pend_d;
   logic               resp_valid_q, resp_valid_d;
   logic               resp_taken_q, resp_taken_d;

   logic [W_FLAGS-1:0] eval_flags;
   logic               eval_taken;
   logic               accept;

   // The last outstanding write landing this cycle makes flags final, so accept and bypass.
   assign req_ready_o = ~flush_i &
                        ((pend_q == '0) |
                         ((pend_q == W_PEND'(1)) & fwe_i & ~fissue_i));
   assign accept      = req_valid_i & req_ready_o;
   assign eval_flags  = fwe_i ? flags_i : flags_q;

   cond_decode u_cond_decode (
      .cond_i  (req_cond_i),
      .flags_i (eval_flags),
      .taken_o (eval_taken)
   );

   always_comb begin
      flags_d      = fwe_i ? flags_i : flags_q;
      pend_d       = pend_q;
      resp_valid_d = accept;
      resp_taken_d = accept & eval_taken;
      if (flush_i) begin
         pend_d = '0;
      end else if (fissue_i & ~fwe_i) begin
         if (pend_q != PEND_MAX) pend_d = pend_q + W_PEND'(1);
      end else if (fwe_i & ~fissue_i) begin
         if (pend_q != '0) pend_d = pend_q - W_PEND'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q      <= '0;
         pend_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_taken_q <= 1'b0;
      end else begin
         flags_q      <= flags_d;
         pend_q       <= pend_d;
         resp_valid_q <= resp_valid_d;
         resp_taken_q <= resp_taken_d;
      end
   end

   assign flags_o      = flags_q;
   assign pend_o       = pend_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_taken_o = resp_taken_q;

endmodule

// File: tb/tb_exec_cond_eval.sv
// Scoreboard bench for exec_cond_eval: directed scenarios, full cond x flags sweep,
// then randomized traffic against a reference model of flags, pending count and conditions.
module tb_exec_cond_eval;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush, fissue, fwe, req_valid;
   logic [3:0] flags_in, req_cond;
   logic       req_ready_o, resp_valid_o, resp_taken_o;
   logic [3:0] flags_o;
   logic [2:0] pend_o;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [3:0] m_flags;
   int         m_pend;
   bit         exp_q[$];

   always #5 clk = ~clk;

   exec_cond_eval dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush),
      .fissue_i     (fissue),
      .fwe_i        (fwe),
      .flags_i      (flags_in),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready_o),
      .req_cond_i   (req_cond),
      .resp_valid_o (resp_valid_o),
      .resp_taken_o (resp_taken_o),
      .flags_o      (flags_o),
      .pend_o       (pend_o)
   );

   // Odd codes are the complement of the even code below them; F is the complement of AL.
   function automatic bit ref_taken(input logic [3:0] c, input logic [3:0] f);
      bit v, s, z, cy;
      bit base [8];
      v = f[3]; s = f[2]; z = f[1]; cy = f[0];
      base[0] = z;
      base[1] = cy;
      base[2] = s;
      base[3] = v;
      base[4] = cy && !z;
      base[5] = (s == v);
      base[6] = !z && (s == v);
      base[7] = 1'b1;
      return base[c[3:1]] ^ c[0];
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic monitor();
      bit e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("resp_valid", {7'd0, resp_valid_o}, 8'd1);
            chk("resp_taken", {7'd0, resp_taken_o}, {7'd0, e});
         end else begin
            chk("resp_idle", {6'd0, resp_valid_o, resp_taken_o}, 8'd0);
         end
      end
   endtask

   task automatic model_reset();
      m_flags = 4'h0;
      m_pend  = 0;
      exp_q.delete();
   endtask

   // One clock cycle: drive, check at negedge, advance model at posedge.
   task automatic cyc(input bit fis, input bit fw, input logic [3:0] fl,
                      input bit rv, input logic [3:0] cond, input bit fsh,
                      output bit rdy);
      bit acc, tk;
      int np;
      fissue = fis; fwe = fw; flags_in = fl;
      req_valid = rv; req_cond = cond; flush = fsh;
      rdy = !fsh && (m_pend == 0 || (m_pend == 1 && fw && !fis));
      @(negedge clk);
      chk("req_ready", {7'd0, req_ready_o}, {7'd0, rdy});
      chk("flags_o", {4'd0, flags_o}, {4'd0, m_flags});
      chk("pend_o", {5'd0, pend_o}, m_pend[7:0]);
      acc = rv && rdy;
      tk  = ref_taken(cond, fw ? fl : m_flags);
      @(posedge clk);
      if (acc) exp_q.push_back(tk);
      if (fw) m_flags = fl;
      np = m_pend + int'(fis) - int'(fw);
      if (np < 0) np = 0;
      if (np > 7) np = 7;
      if (fsh) np = 0;
      m_pend = np;
      #1;
   endtask

   task automatic idle(input int n);
      bit r;
      for (int i = 0; i < n; i++) cyc(0, 0, 4'h0, 0, 4'h0, 0, r);
   endtask

   initial begin
      bit r, hold, fis, fw, rv, fsh;
      logic [3:0] hc, cond, fl;

      rst_n = 1'b0;
      flush = 0; fissue = 0; fwe = 0; req_valid = 0;
      flags_in = 4'h0; req_cond = 4'h0;
      model_reset();
      fork monitor(); join_none

      // reset values
      @(negedge clk);
      chk("rst_flags", {4'd0, flags_o}, 8'd0);
      chk("rst_pend", {5'd0, pend_o}, 8'd0);
      chk("rst_resp_valid", {7'd0, resp_valid_o}, 8'd0);
      chk("rst_ready", {7'd0, req_ready_o}, 8'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      cyc(0, 0, 4'h0, 1, 4'hE, 0, r);            // AL right after reset
      idle(1);

      // write Z, then EQ / NE
      cyc(0, 1, 4'b0010, 0, 4'h0, 0, r);
      cyc(0, 0, 4'h0, 1, 4'h0, 0, r);
      cyc(0, 0, 4'h0, 1, 4'h1, 0, r);
      idle(1);

      // two issues, GE stalled until second write lands via bypass
      cyc(1, 0, 4'h0, 0, 4'h0, 0, r);
      cyc(1, 0, 4'h0, 1, 4'hA, 0, r);
      cyc(0, 0, 4'h0, 1, 4'hA, 0, r);
      cyc(0, 1, 4'b1000, 1, 4'hA, 0, r);
      cyc(0, 1, 4'b1100, 1, 4'hA, 0, r);
      idle(1);
      chk("stall_flags_after", {4'd0, flags_o}, 8'h0C);

      // simultaneous issue + write at pend=1
      cyc(1, 0, 4'h0, 0, 4'h0, 0, r);
      cyc(1, 1, 4'h5, 1, 4'h2, 0, r);
      cyc(0, 1, 4'h1, 1, 4'h2, 0, r);
      idle(1);

      // flush with three in flight and a stalled request
      for (int i = 0; i < 3; i++) cyc(1, 0, 4'h0, 0, 4'h0, 0, r);
      cyc(0, 0, 4'h0, 1, 4'h3, 0, r);
      cyc(0, 0, 4'h0, 1, 4'h3, 1, r);
      cyc(0, 0, 4'h0, 1, 4'h3, 0, r);
      idle(1);

      // saturation at 7 outstanding, then drain
      for (int i = 0; i < 9; i++) cyc(1, 0, 4'h0, 0, 4'h0, 0, r);
      for (int i = 0; i < 8; i++) cyc(0, 1, 4'($urandom), 1, 4'h4, 0, r);
      idle(1);

      // reset in the middle of a stall: no response for the stalled request
      cyc(1, 0, 4'h0, 0, 4'h0, 0, r);
      cyc(1, 0, 4'h0, 1, 4'hE, 0, r);
      fissue = 0; req_valid = 1; req_cond = 4'hE;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_pend", {5'd0, pend_o}, 8'd0);
      chk("midrst_flags", {4'd0, flags_o}, 8'd0);
      req_valid = 0;
      @(posedge clk); #1;
      idle(1);
      rst_n = 1'b1;
      idle(1);

      // full sweep: bypassed and registered flags
      for (int f = 0; f < 16; f++) begin
         for (int c = 0; c < 16; c++) begin
            cyc(0, 1, 4'(f), 1, 4'(c), 0, r);
            cyc(0, 0, 4'h0, 1, 4'(c), 0, r);
         end
      end

      // randomized traffic; stalled requests keep their condition stable
      hold = 0; hc = 4'h0;
      for (int i = 0; i < 2000; i++) begin
         fsh = ($urandom % 32) == 0;
         fis = ($urandom % 10) < 3;
         fw  = (m_pend > 0) ? (($urandom % 10) < 4) : (($urandom % 20) == 0);
         fl  = 4'($urandom);
         if (hold) begin
            rv = 1; cond = hc;
         end else begin
            rv = ($urandom % 10) < 6; cond = 4'($urandom);
         end
         cyc(fis, fw, fl, rv, cond, fsh, r);
         hold = rv && !r;
         hc   = cond;
      end

      idle(3);
      chk("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
